// File: rtl/dt_gen_pkg.sv
// Shared types and helpers for the dead-time generator: channel state
// encoding, default timing constants and the select-code decode.
package dt_gen_pkg;

    localparam int unsigned DT_STEP_DEF  = 2;
    localparam int unsigned MAX_CODE_DEF = 9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DT_HI = 3'd1,
        ST_HI_ON = 3'd2,
        ST_DT_LO = 3'd3,
        ST_LO_ON = 3'd4
    } dt_state_e;

    // Codes above max_code saturate to the longest legal dead time.
    function automatic int unsigned dt_cycles(input int unsigned code,
                                              input int unsigned max_code,
                                              input int unsigned step);
        int unsigned c;
        c = (code > max_code) ? max_code : code;
        return (c + 1) * step;
    endfunction

endpackage

// File: rtl/dt_gen_chan.sv
// One dead-time channel: complementary gate FSM with a down-counter that is
// loaded from the decoded select code only when an interval starts.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | disabled or faulted, both gates off
// ST_DT_HI | dead time before high side, both gates off
// ST_HI_ON | high-side gate on
// ST_DT_LO | dead time before low side, both gates off
// ST_LO_ON | low-side gate on
module dt_chan
    import dt_gen_pkg::*;
#(
    parameter int unsigned SEL_W    = 4,
    parameter int unsigned CNT_W    = 6,
    parameter int unsigned DT_STEP  = DT_STEP_DEF,
    parameter int unsigned MAX_CODE = MAX_CODE_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_pwm,
    input  logic [SEL_W-1:0] i_sel,
    input  logic             i_kill,
    output logic             o_hi,
    output logic             o_lo,
    output logic             o_busy
);

    dt_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_load;
    logic             from_on_q, from_on_d;
    logic             hi_q, lo_q, busy_q;

    assign cnt_load = CNT_W'(dt_cycles(32'(i_sel), MAX_CODE, DT_STEP) - 1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        from_on_d = from_on_q;
        if (i_kill || !i_en) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            from_on_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = i_pwm ? ST_DT_HI : ST_DT_LO;
                    cnt_d     = cnt_load;
                    from_on_d = 1'b0;
                end
                ST_DT_HI: begin
                    // An abort only skips the dead time when the opposite gate
                    // was really on before; after IDLE a full interval is owed.
                    if (!i_pwm) begin
                        if (from_on_q) begin
                            state_d = ST_LO_ON;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_DT_LO;
                            cnt_d   = cnt_load;
                        end
                    end else if (cnt_q == '0) begin
                        state_d = ST_HI_ON;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_HI_ON: begin
                    if (!i_pwm) begin
                        state_d   = ST_DT_LO;
                        cnt_d     = cnt_load;
                        from_on_d = 1'b1;
                    end
                end
                ST_DT_LO: begin
                    if (i_pwm) begin
                        if (from_on_q) begin
                            state_d = ST_HI_ON;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_DT_HI;
                            cnt_d   = cnt_load;
                        end
                    end else if (cnt_q == '0) begin
                        state_d = ST_LO_ON;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_LO_ON: begin
                    if (i_pwm) begin
                        state_d   = ST_DT_HI;
                        cnt_d     = cnt_load;
                        from_on_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            from_on_q <= 1'b0;
            hi_q      <= 1'b0;
            lo_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            from_on_q <= from_on_d;
            hi_q      <= (state_d == ST_HI_ON);
            lo_q      <= (state_d == ST_LO_ON);
            busy_q    <= (state_d == ST_DT_HI) || (state_d == ST_DT_LO);
        end
    end

    assign o_hi   = hi_q;
    assign o_lo   = lo_q;
    assign o_busy = busy_q;

endmodule

// File: rtl/dt_gen.sv
// Multi-channel dead-time generator top: fault latch shared by all channels
// and slicing of the packed select bus into per-channel codes.
module dt_gen
    import dt_gen_pkg::*;
#(
    parameter int unsigned N_CH     = 2,
    parameter int unsigned SEL_W    = 4,
    parameter int unsigned CNT_W    = 6,
    parameter int unsigned DT_STEP  = DT_STEP_DEF,
    parameter int unsigned MAX_CODE = MAX_CODE_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [N_CH-1:0]       i_en,
    input  logic [N_CH-1:0]       i_pwm,
    input  logic [N_CH*SEL_W-1:0] i_sel,
    input  logic                  i_fault,
    input  logic                  i_fault_clr,
    output logic [N_CH-1:0]       o_hi,
    output logic [N_CH-1:0]       o_lo,
    output logic [N_CH-1:0]       o_dt_busy,
    output logic                  o_fault
);

    logic fault_q, fault_d;
    logic kill;

    // A new fault always wins over a simultaneous clear.
    assign fault_d = i_fault | (fault_q & ~i_fault_clr);
    assign kill    = i_fault | fault_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign o_fault = fault_q;

    for (genvar c = 0; c < N_CH; c++) begin : g_chan
        dt_chan #(
            .SEL_W   (SEL_W),
            .CNT_W   (CNT_W),
            .DT_STEP (DT_STEP),
            .MAX_CODE(MAX_CODE)
        ) u_chan (
            .i_clk  (i_clk),
            .i_rst_n(i_rst_n),
            .i_en   (i_en[c]),
            .i_pwm  (i_pwm[c]),
            .i_sel  (i_sel[c*SEL_W +: SEL_W]),
            .i_kill (kill),
            .o_hi   (o_hi[c]),
            .o_lo   (o_lo[c]),
            .o_busy (o_dt_busy[c])
        );
    end

endmodule

// File: tb/tb_dt_gen.sv
// Directed bench for dt_gen: table-driven dead-time sweep plus hand-written
// sequences for select latching, short-pulse abort, enable, fault and reset.
module tb_dt_gen;

    logic       clk;
    logic       rst_n;
    logic [1:0] en;
    logic [1:0] pwm;
    logic [7:0] sel;
    logic       fault;
    logic       fault_clr;
    logic [1:0] hi;
    logic [1:0] lo;
    logic [1:0] busy;
    logic       fault_o;

    int checks = 0;
    int fails  = 0;

    dt_gen dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_en       (en),
        .i_pwm      (pwm),
        .i_sel      (sel),
        .i_fault    (fault),
        .i_fault_clr(fault_clr),
        .o_hi       (hi),
        .o_lo       (lo),
        .o_dt_busy  (busy),
        .o_fault    (fault_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Both gates must never be on together, checked on every falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ((hi & lo) != 2'b00) begin
                fails++;
                $display("FAIL invariant hi=%b lo=%b required hi&lo=00", hi, lo);
            end
        end
    end

    // Drive both channels to level lvl; count both-off and busy samples until
    // the target gate rises. -1 means it never rose within the budget.
    task automatic transition(input logic lvl, output int g0, output int g1,
                              output int b0, output int b1);
        int g[2];
        int b[2];
        bit done[2];
        g = '{0, 0};
        b = '{0, 0};
        done = '{1'b0, 1'b0};
        pwm = {lvl, lvl};
        for (int n = 0; n < 64 && !(done[0] && done[1]); n++) begin
            tick();
            for (int c = 0; c < 2; c++) begin
                if (!done[c]) begin
                    if ((lvl ? hi[c] : lo[c]) == 1'b1) begin
                        done[c] = 1'b1;
                    end else begin
                        if (!hi[c] && !lo[c]) g[c]++;
                        if (busy[c]) b[c]++;
                    end
                end
            end
        end
        g0 = done[0] ? g[0] : -1;
        g1 = done[1] ? g[1] : -1;
        b0 = done[0] ? b[0] : -1;
        b1 = done[1] ? b[1] : -1;
    endtask

    typedef struct {
        logic [3:0] sel;
        int         gap;
    } vec_t;

    vec_t vt[16];

    initial begin : main
        int g0, g1, b0, b1;
        int cnt, lows;
        bit seen;

        vt = '{'{4'd0, 2},  '{4'd1, 4},  '{4'd2, 6},  '{4'd3, 8},
               '{4'd4, 10}, '{4'd5, 12}, '{4'd6, 14}, '{4'd7, 16},
               '{4'd8, 18}, '{4'd9, 20}, '{4'd10, 20}, '{4'd11, 20},
               '{4'd12, 20}, '{4'd13, 20}, '{4'd14, 20}, '{4'd15, 20}};

        rst_n = 1'b0; en = 2'b00; pwm = 2'b00; sel = 8'h00;
        fault = 1'b0; fault_clr = 1'b0;
        #1;
        chk("reset_hi", int'(hi), 0);
        chk("reset_lo", int'(lo), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_fault", int'(fault_o), 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // First interval from IDLE, sel=0 -> 2 cycles
        en = 2'b11; pwm = 2'b11; sel = 8'h00;
        tick();
        chk("start_e1_hi", int'(hi), 0);
        chk("start_e1_busy", int'(busy), 3);
        tick();
        chk("start_e2_hi", int'(hi), 0);
        chk("start_e2_busy", int'(busy), 3);
        tick();
        chk("start_e3_hi", int'(hi), 3);
        chk("start_e3_busy", int'(busy), 0);
        pwm = 2'b00;
        tick();
        chk("fall_e1_hi", int'(hi), 0);
        chk("fall_e1_lo", int'(lo), 0);
        tick();
        chk("fall_e2_lo", int'(lo), 0);
        tick();
        chk("fall_e3_lo", int'(lo), 3);
        transition(1'b1, g0, g1, b0, b1);
        chk("first_rise_gap0", g0, 2);
        chk("first_rise_gap1", g1, 2);

        // Sweep: ch0 uses code i, ch1 uses code 15-i
        for (int i = 0; i < 16; i++) begin
            sel = {vt[15-i].sel, vt[i].sel};
            transition(1'b0, g0, g1, b0, b1);
            chk($sformatf("sweep_hl_gap0_c%0d", i), g0, vt[i].gap);
            chk($sformatf("sweep_hl_gap1_c%0d", 15-i), g1, vt[15-i].gap);
            chk($sformatf("sweep_hl_busy0_c%0d", i), b0, vt[i].gap);
            transition(1'b1, g0, g1, b0, b1);
            chk($sformatf("sweep_lh_gap0_c%0d", i), g0, vt[i].gap);
            chk($sformatf("sweep_lh_gap1_c%0d", 15-i), g1, vt[15-i].gap);
            chk($sformatf("sweep_lh_busy1_c%0d", 15-i), b1, vt[15-i].gap);
        end

        // Select change mid-interval does not affect the running interval
        sel = {4'd9, 4'd9};
        pwm = 2'b00;
        cnt = -1; lows = 0;
        for (int n = 0; n < 64; n++) begin
            tick();
            if (n == 3) sel = 8'h00;
            if (lo[0]) begin
                cnt = lows;
                break;
            end
            if (!hi[0] && !lo[0]) lows++;
        end
        chk("selchg_gap_current", cnt, 20);
        transition(1'b1, g0, g1, b0, b1);
        chk("selchg_gap_next0", g0, 2);
        chk("selchg_gap_next1", g1, 2);

        // Short pulse during DT_HI aborts back to low side
        sel = {4'd4, 4'd4};
        transition(1'b0, g0, g1, b0, b1);
        chk("abort_setup_gap0", g0, 10);
        pwm = 2'b01;
        tick();
        chk("abort_dt_lo0", int'(lo[0]), 0);
        chk("abort_dt_busy0", int'(busy[0]), 1);
        pwm = 2'b00;
        tick();
        chk("abort_back_lo0", int'(lo[0]), 1);
        chk("abort_back_busy0", int'(busy[0]), 0);
        seen = 1'b0;
        for (int n = 0; n < 15; n++) begin
            tick();
            if (hi[0]) seen = 1'b1;
        end
        chk("abort_hi_never", int'(seen), 0);
        chk("abort_ch1_lo", int'(lo[1]), 1);

        // Enable low forces IDLE; re-enable gives a full interval
        en = 2'b10;
        tick();
        chk("en_off_lo0", int'(lo[0]), 0);
        chk("en_off_busy0", int'(busy[0]), 0);
        chk("en_off_lo1", int'(lo[1]), 1);
        en = 2'b11;
        transition(1'b0, g0, g1, b0, b1);
        chk("en_back_gap0", g0, 10);
        chk("en_back_gap1", g1, 0);

        // Fault latch, clear ignored while fault asserted, full dt after clear
        sel = {4'd1, 4'd1};
        transition(1'b1, g0, g1, b0, b1);
        chk("fault_setup_gap0", g0, 4);
        fault = 1'b1;
        tick();
        chk("fault_hi", int'(hi), 0);
        chk("fault_lo", int'(lo), 0);
        chk("fault_latched", int'(fault_o), 1);
        fault = 1'b0;
        tick();
        chk("fault_hold", int'(fault_o), 1);
        chk("fault_hold_hi", int'(hi), 0);
        fault = 1'b1; fault_clr = 1'b1;
        tick();
        fault = 1'b0; fault_clr = 1'b0;
        chk("fault_clr_ignored", int'(fault_o), 1);
        tick();
        chk("fault_still", int'(fault_o), 1);
        chk("fault_still_hi", int'(hi), 0);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("fault_cleared", int'(fault_o), 0);
        chk("fault_cleared_hi", int'(hi), 0);
        cnt = 0; lows = -1;
        for (int n = 0; n < 64; n++) begin
            tick();
            if (hi[0]) begin
                lows = n;
                break;
            end
            if (busy[0]) cnt++;
        end
        chk("fault_restart_low", lows, 4);
        chk("fault_restart_busy", cnt, 4);

        // Asynchronous reset mid-interval clears outputs immediately
        sel = {4'd9, 4'd9};
        pwm = 2'b00;
        for (int n = 0; n < 5; n++) tick();
        chk("pre_reset_busy", int'(busy), 3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_hi", int'(hi), 0);
        chk("async_rst_lo", int'(lo), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_fault", int'(fault_o), 0);
        tick();
        rst_n = 1'b1;

        // Random activity; the invariant monitor checks every cycle
        for (int n = 0; n < 3000; n++) begin
            tick();
            en = ($urandom_range(0, 19) == 0) ? 2'($urandom) : 2'b11;
            for (int c = 0; c < 2; c++)
                if ($urandom_range(0, 5) == 0) pwm[c] = ~pwm[c];
            if ($urandom_range(0, 7) == 0) sel = 8'($urandom);
            fault = ($urandom_range(0, 149) == 0);
            fault_clr = ($urandom_range(0, 9) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
